// File: rtl/masked_bit_decoder.sv
// masked_bit_decoder: unmasks the three-share XOR masking stage output,
// realigns it to s1_vld_i, and deserializes the recovered bits LSB-first into
// WIDTH-bit words on a single-entry valid/ready port.
// Optional feature macro: MASKED_DEC_PARITY_EN (adds a trailing even-parity
// bit per frame and the sticky perr_o flag; otherwise perr_o is tied 0).
module masked_bit_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s1_vld_i,
  input  logic             s2_i,
  input  logic             r_i,
  input  logic             o_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             ovf_o,
  output logic             perr_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             mask_q;
  logic             vld_d1;
  logic             vld_d2;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  logic             b_c;
  logic             accept_c;
  logic             collect_acc_c;
  logic             last_c;
  logic [WIDTH-1:0] shreg_next_c;
  logic [WIDTH-1:0] word_c;
  logic             load_c;
`ifdef MASKED_DEC_PARITY_EN
  logic             perr_set_c;
`endif

  // Recovered bit and acceptance qualifiers
  assign b_c           = o_i ^ mask_q;
  assign accept_c      = vld_d2;
  assign collect_acc_c = accept_c && (state_q == COLLECT);
  assign last_c        = collect_acc_c && (bit_cnt == CW'(WIDTH - 1));
  assign shreg_next_c  = WIDTH'({b_c, shreg} >> 1);

  // Mask share register and two-stage valid delay line matching the masking skew
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= 1'b0;
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
    end else begin
      mask_q <= s2_i ^ r_i;
      vld_d1 <= s1_vld_i;
      vld_d2 <= vld_d1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
`ifdef MASKED_DEC_PARITY_EN
          if (last_c) state_d = PARITY;
`endif
        end
        PARITY: begin
          if (accept_c) state_d = COLLECT;
        end
      endcase
    end
  end

  // FSM outputs: word completion and parity verdict
  always_comb begin
    load_c = 1'b0;
`ifdef MASKED_DEC_PARITY_EN
    word_c     = shreg;
    perr_set_c = 1'b0;
    if ((state_q == PARITY) && accept_c) begin
      if (b_c == ^shreg) begin
        load_c = 1'b1;
      end else begin
        perr_set_c = 1'b1;
      end
    end
`else
    word_c = shreg_next_c;
    if (last_c) load_c = 1'b1;
`endif
  end

  // Deserializer shift register and bit counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear_i) begin
      bit_cnt <= '0;
    end else if (collect_acc_c) begin
      shreg   <= shreg_next_c;
      bit_cnt <= last_c ? '0 : CW'(bit_cnt + CW'(1));
    end
  end

  // Single-entry holding register with overflow detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (load_c) begin
      if (!valid_o || ready_i) begin
        data_o  <= word_c;
        valid_o <= 1'b1;
      end else begin
        ovf_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef MASKED_DEC_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perr_o <= 1'b0;
    end else if (clear_i) begin
      perr_o <= 1'b0;
    end else if (perr_set_c) begin
      perr_o <= 1'b1;
    end
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: doc/masked_bit_decoder.md
# masked_bit_decoder

Receive-side counterpart of the three-share XOR masking stage. It takes the masked output bit stream `o_i` plus the two mask shares (`s2_i`, `r_i`) as they are applied to the masking stage. From these it recovers the original `s1` bit stream, compensating for the masking stage's two-cycle skew. Recovered bits are deserialized LSB-first into `WIDTH`-bit words and delivered over a valid/ready output port, with sticky overflow and (optionally) parity error flags. It sits beside the masking stage in the fault-injection benchmark harness as the golden unmasking checker.

## Interface
- `WIDTH`, 8, recovered word width in bits (2..32).
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `s1_vld_i`  in  1  high in the cycle a valid `s1` bit is applied to the masking stage.
- `s2_i`  in  1  share `s2`, same cycle alignment as the masking stage's `s2` input.
- `r_i`  in  1  share `r`, same cycle alignment as the masking stage's `r` input.
- `o_i`  in  1  masked output `o` of the masking stage.
- `clear_i`  in  1  synchronous clear of bit counter, FSM and sticky flags.
- `data_o`  out  WIDTH  recovered word.
- `valid_o`  out  1  `data_o` holds an undelivered word.
- `ready_i`  in  1  consumer accepts the word when `valid_o && ready_i`.
- `ovf_o`  out  1  sticky: a completed word was dropped.
- `perr_o`  out  1  sticky: parity mismatch (`PARITY_EN` only).

## Operation
- Masking relation: `o(t) = s1(t-2) ^ s2(t-1) ^ r(t-1)`.
- Unmasking:
  - `mask_q <= s2_i ^ r_i` every cycle, unconditionally.
  - Recovered bit `b(t) = o_i ^ mask_q` equals `s1(t-2)`.
- Valid alignment:
  - `vld_d1 <= s1_vld_i`; `vld_d2 <= vld_d1`.
  - `b` is accepted only in cycles where `vld_d2 = 1`.
- Deserializer:
  - `shreg <= {b, shreg[WIDTH-1:1]}` on each accepted bit, so the first bit lands in bit 0.
  - `bit_cnt` counts 0..WIDTH-1.
- FSM states: `COLLECT` and `PARITY`; `PARITY` is reachable only with `PARITY_EN`.
  - `COLLECT`: on an accepted bit with `bit_cnt == WIDTH-1`, the word is complete and `bit_cnt` returns to 0. Without `PARITY_EN`, deliver the word and stay in `COLLECT`. With `PARITY_EN`, go to `PARITY`.
  - `PARITY`: the next accepted bit is the even-parity bit. If it matches, deliver the word; otherwise set `perr_o` and discard the word. Return to `COLLECT` in either case.
- Delivery uses a single holding register:
  - If `valid_o = 0`, or `valid_o && ready_i` in the same cycle, load `data_o` and set `valid_o = 1`.
  - Otherwise drop the word, set `ovf_o`, and leave `data_o` unchanged.
- Handshake:
  - `valid_o && ready_i` with no new word clears `valid_o`.
  - `data_o` is stable while `valid_o && !ready_i`.
- `clear_i` has priority over every other event. It clears `bit_cnt`, `ovf_o`, `perr_o`, the FSM (to `COLLECT`) and `valid_o`. It does not clear `mask_q` or the valid delay line.
- Gaps in `s1_vld_i` are allowed. Partial words are held indefinitely.

## Timing
- Reset values:
  - Outputs: `data_o = 0`, `valid_o = 0`, `ovf_o = 0`, `perr_o = 0`.
  - Internal: `mask_q = 0`, `vld_d1 = vld_d2 = 0`, `bit_cnt = 0`, FSM = `COLLECT`.
- Bit latency: a bit applied with `s1_vld_i` at cycle t is accepted at edge t+2.
- Word latency:
  - `valid_o` rises 3 cycles after the last data bit's `s1_vld_i`, or 3 cycles after the parity bit's with `PARITY_EN`.
  - Back-to-back words with a continuously high `s1_vld_i` need `ready_i` high at least once per WIDTH (or WIDTH+1) cycles to avoid overflow.
- Reset mid-word: the partial word is lost, and the bits in the delay line at reset are discarded.
- Sticky flags stay high until `clear_i` or `rst_i`.

## Configuration
- `MASKED_DEC_PARITY_EN`:
  - Defined: frames are WIDTH data bits plus 1 even-parity bit, and the `PARITY` state and `perr_o` logic are present.
  - Undefined: frames are WIDTH bits, `PARITY` is unreachable, and `perr_o` is tied 0.

## Test plan
- Reset, then drive `s1 = 1,0,1,1,0,0,1,0` with `s1_vld_i = 1` and random `s2`/`r`, `ready_i = 1` (WIDTH=8, macro off). Required: `data_o = 0x4D`, `valid_o` high for 1 cycle, 3 cycles after the 8th bit.
- Same stimulus with `ready_i = 0`, then a second word `0xFF`. Required: `data_o` stays `0x4D`, `ovf_o = 1`; `clear_i` then gives `ovf_o = 0`, `valid_o = 0`.
- Gappy `s1_vld_i` (1,0,0,1,...) for word `0xA5`. Required: `data_o = 0xA5`, with no bits accepted in gap cycles.
- `MASKED_DEC_PARITY_EN` on, word `0x3C` with parity 0. Required: delivered. Same word with parity 1: not delivered, `perr_o = 1`.
- Assert `rst_i` asynchronously after 5 bits, release, then send `0x81`. Required: all outputs 0 during reset, then `data_o = 0x81` with no residue from the partial word.
- Completion coinciding with `valid_o && ready_i`. Required: new word loaded, `valid_o` stays 1, `ovf_o = 0`.
